// File: rtl/riscv_pkg.sv
`default_nettype none
//==============================================================================
// Module      : riscv_pkg
// Description : Shared definitions for the unified-memory arbiter: default
//               bus widths, default abort limit, arbiter FSM encoding and a
//               small state helper.
// Revision    : 1.0 - initial release
//==============================================================================
package riscv_pkg;

  localparam int c_DEF_ADDR_W   = 32;
  localparam int c_DEF_DATA_W   = 32;
  localparam int c_DEF_MAX_WAIT = 15;

  // Wide enough for the largest legal MAX_WAIT (255).
  localparam int c_WDOG_CNT_W   = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  // True while a memory transaction is outstanding.
  function automatic logic is_busy(input arb_state_e s);
    return (s != IDLE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/arb_wdog.sv
`default_nettype none
//==============================================================================
// Module      : arb_wdog
// Description : Wait counter for the memory arbiter. Counts busy cycles
//               without an acknowledge and flags the cycle in which the
//               MAX_WAIT-th unacknowledged cycle completes. An ack in that
//               same cycle suppresses the flag.
// Revision    : 1.0 - initial release
//==============================================================================
module arb_wdog
  import riscv_pkg::*;
#(
  parameter int MAX_WAIT = c_DEF_MAX_WAIT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_busy,
  input  logic i_ack,
  output logic o_timeout
);

  // Counter value seen during the last allowed cycle of a transaction.
  localparam logic [c_WDOG_CNT_W-1:0] c_LIMIT = c_WDOG_CNT_W'(MAX_WAIT - 1);

  logic [c_WDOG_CNT_W-1:0] r_cnt;

  // Held at zero while idle so every transaction starts from a clean count.
  always_ff @(posedge clk) begin
    if (rst || !i_busy) begin
      r_cnt <= '0;
    end else if (!i_ack) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_timeout = i_busy & ~i_ack & (r_cnt == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : mem_arbiter
// Description : Arbitrates instruction fetches and loads/stores onto one
//               single-ported memory. One transaction at a time; responses
//               are registered and flagged by one-cycle valid pulses. A
//               watchdog aborts transactions that are never acknowledged.
//               Build option ARB_FAIR_EN: alternate grants on simultaneous
//               requests instead of fixed data-over-fetch priority.
// Revision    : 1.0 - initial release
//==============================================================================
module mem_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_W   = c_DEF_ADDR_W,
  parameter int DATA_W   = c_DEF_DATA_W,
  parameter int MAX_WAIT = c_DEF_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  // Instruction fetch port
  input  logic              inst_ce_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  output logic [DATA_W-1:0] inst_o,
  output logic              inst_valid_o,
  // Load/store port
  input  logic              data_ce_i,
  input  logic              data_we_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              data_valid_o,
  // CPU hold
  output logic              stall_o,
  // Unified memory port
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  // Sticky timeout flag
  output logic              err_o
);

  arb_state_e        r_state;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_inst;
  logic              r_inst_valid;
  logic [DATA_W-1:0] r_data_rdata;
  logic              r_data_valid;
  logic              r_err;
  // Fetch that lost arbitration to a data access; served on return to IDLE.
  logic              r_inst_pend;
  logic [ADDR_W-1:0] r_inst_pend_addr;
`ifdef ARB_FAIR_EN
  // 1 = last grant went to the data port, 0 = fetch port.
  logic              r_last_data;
`endif

  logic              w_busy;
  logic              w_timeout;
  logic              w_inst_req;
  logic [ADDR_W-1:0] w_inst_addr;
  logic              w_grant_data;
  logic              w_grant_inst;

  assign w_busy      = is_busy(r_state);
  assign w_inst_req  = r_inst_pend | inst_ce_i;
  assign w_inst_addr = r_inst_pend ? r_inst_pend_addr : inst_addr_i;

`ifdef ARB_FAIR_EN
  // On contention the port that did not win last time goes first.
  assign w_grant_data = data_ce_i & (~w_inst_req | ~r_last_data);
`else
  // Data beats a new fetch, but a fetch already deferred once is not deferred again.
  assign w_grant_data = data_ce_i & ~r_inst_pend;
`endif
  assign w_grant_inst = w_inst_req & ~w_grant_data;

  // A deferred fetch counts as a pending request, keeping the CPU held.
  assign stall_o = w_busy | inst_ce_i | data_ce_i | r_inst_pend;

  arb_wdog #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .i_busy    (w_busy),
    .i_ack     (mem_ack_i),
    .o_timeout (w_timeout)
  );

  // Arbiter FSM: grant in IDLE, hold the memory request, capture response or abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_mem_req        <= 1'b0;
      r_mem_we         <= 1'b0;
      r_mem_addr       <= '0;
      r_mem_wdata      <= '0;
      r_inst           <= '0;
      r_inst_valid     <= 1'b0;
      r_data_rdata     <= '0;
      r_data_valid     <= 1'b0;
      r_err            <= 1'b0;
      r_inst_pend      <= 1'b0;
      r_inst_pend_addr <= '0;
`ifdef ARB_FAIR_EN
      r_last_data      <= 1'b0;
`endif
    end else begin
      r_inst_valid <= 1'b0;
      r_data_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_data) begin
            r_state     <= BUSY_D;
            r_mem_req   <= 1'b1;
            r_mem_we    <= data_we_i;
            r_mem_addr  <= data_addr_i;
            r_mem_wdata <= data_wdata_i;
`ifdef ARB_FAIR_EN
            r_last_data <= 1'b1;
`endif
            if (inst_ce_i && !r_inst_pend) begin
              r_inst_pend      <= 1'b1;
              r_inst_pend_addr <= inst_addr_i;
            end
          end else if (w_grant_inst) begin
            r_state     <= BUSY_I;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= w_inst_addr;
            r_mem_wdata <= '0;
            r_inst_pend <= 1'b0;
`ifdef ARB_FAIR_EN
            r_last_data <= 1'b0;
`endif
          end
        end
        BUSY_I: begin
          if (mem_ack_i || w_timeout) begin
            r_state      <= IDLE;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_inst       <= mem_ack_i ? mem_rdata_i : '0;
            r_inst_valid <= 1'b1;
            if (!mem_ack_i) begin
              r_err <= 1'b1;
            end
          end
        end
        BUSY_D: begin
          if (mem_ack_i || w_timeout) begin
            r_state      <= IDLE;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_data_rdata <= mem_ack_i ? mem_rdata_i : '0;
            r_data_valid <= 1'b1;
            if (!mem_ack_i) begin
              r_err <= 1'b1;
            end
          end
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req_o    = r_mem_req;
  assign mem_we_o     = r_mem_we;
  assign mem_addr_o   = r_mem_addr;
  assign mem_wdata_o  = r_mem_wdata;
  assign inst_o       = r_inst;
  assign inst_valid_o = r_inst_valid;
  assign data_rdata_o = r_data_rdata;
  assign data_valid_o = r_data_valid;
  assign err_o        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. Directed requests push
//               expected memory-bus transactions and expected responses into
//               queues; a monitor compares them against the DUT outputs.
//               Expected ordering follows ARB_FAIR_EN when it is defined.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_mem_arbiter;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_t;

  typedef struct {
    bit          is_data;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_ce_i;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        data_ce_i;
  logic        data_we_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;
  logic        data_valid_o;
  logic        stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        err_o;

  int   n_checks = 0;
  int   n_fail   = 0;
  mem_t exp_mem[$];
  rsp_t exp_rsp[$];

  // Memory model controls
  int   ack_delay = 0;
  bit   ack_force = 1'b0;
  int   wcnt      = 0;
  bit   ack_done  = 1'b0;
  logic prev_req  = 1'b0;

  mem_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .inst_ce_i    (inst_ce_i),
    .inst_addr_i  (inst_addr_i),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o),
    .data_ce_i    (data_ce_i),
    .data_we_i    (data_we_i),
    .data_addr_i  (data_addr_i),
    .data_wdata_i (data_wdata_i),
    .data_rdata_o (data_rdata_o),
    .data_valid_o (data_valid_o),
    .stall_o      (stall_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_ack_i    (mem_ack_i),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    if (a == 32'h0000_0004) return 32'h0000_0013;
    return a + 32'h1000_0000;
  endfunction

  // Memory model: acknowledge after ack_delay busy cycles, once per request.
  always @(negedge clk) begin
    if (mem_req_o === 1'b1) begin
      if (wcnt == ack_delay && !ack_done) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = rdata_of(mem_addr_o);
        ack_done    = 1'b1;
      end else begin
        mem_ack_i = 1'b0;
      end
      wcnt++;
    end else begin
      mem_ack_i = 1'b0;
      wcnt      = 0;
      ack_done  = 1'b0;
    end
    if (ack_force) begin
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'hBAD0_BAD0;
    end
  end

  // Monitor: memory bus held against the expected transaction, responses popped on valid.
  always @(negedge clk) begin
    if (mem_req_o === 1'b1) begin
      if (exp_mem.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL mem_unexpected: got addr 0x%08h expected no request", mem_addr_o);
      end else begin
        chk1 ("mem_we",    mem_we_o,    exp_mem[0].we);
        chk32("mem_addr",  mem_addr_o,  exp_mem[0].addr);
        chk32("mem_wdata", mem_wdata_o, exp_mem[0].wdata);
      end
    end
    if (mem_req_o === 1'b0 && prev_req === 1'b1 && exp_mem.size() > 0) begin
      void'(exp_mem.pop_front());
    end
    prev_req = mem_req_o;

    if (inst_valid_o === 1'b1 || data_valid_o === 1'b1) begin
      if (exp_rsp.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected: got inst_v=%b data_v=%b expected none", inst_valid_o, data_valid_o);
      end else begin
        rsp_t r;
        r = exp_rsp.pop_front();
        chk1("rsp_is_data", data_valid_o, r.is_data);
        chk1("rsp_is_inst", inst_valid_o, ~r.is_data);
        if (r.is_data) chk32("data_rdata", data_rdata_o, r.data);
        else           chk32("inst_o",     inst_o,       r.data);
      end
    end
  end

  task automatic push_mem(input logic we, input logic [31:0] a, input logic [31:0] w);
    mem_t m;
    m.we = we; m.addr = a; m.wdata = w;
    exp_mem.push_back(m);
  endtask

  task automatic push_rsp(input bit is_data, input logic [31:0] d);
    rsp_t r;
    r.is_data = is_data; r.data = d;
    exp_rsp.push_back(r);
  endtask

  // Present requests; hold the data request until the DUT has granted it.
  task automatic do_req(input bit ic, input logic [31:0] ia, input bit dc,
                        input bit dwe, input logic [31:0] da, input logic [31:0] dw);
    bit granted;
    @(posedge clk); #1;
    inst_ce_i = ic; inst_addr_i = ia;
    data_ce_i = dc; data_we_i = dwe; data_addr_i = da; data_wdata_i = dw;
    granted = !dc;
    for (int k = 0; k < 60 && !granted; k++) begin
      @(posedge clk); #1;
      inst_ce_i = 1'b0;
      if (mem_req_o === 1'b1 && mem_addr_o == da && mem_we_o == dwe) granted = 1'b1;
    end
    if (!dc) begin
      @(posedge clk); #1;
      inst_ce_i = 1'b0;
    end
    data_ce_i = 1'b0;
    data_we_i = 1'b0;
    if (!granted) begin
      n_checks++;
      n_fail++;
      $display("FAIL grant_timeout: got no grant for addr 0x%08h expected grant", da);
    end
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 200 && exp_rsp.size() != 0; k++) @(negedge clk);
    chk32(name, 32'(exp_rsp.size()), 32'd0);
    @(posedge clk);
  endtask

  initial begin
    int hi_cnt;
    rst = 1'b1;
    inst_ce_i = 1'b0; inst_addr_i = '0;
    data_ce_i = 1'b0; data_we_i = 1'b0; data_addr_i = '0; data_wdata_i = '0;
    mem_ack_i = 1'b0; mem_rdata_i = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1 ("rst_mem_req",    mem_req_o,    1'b0);
    chk1 ("rst_mem_we",     mem_we_o,     1'b0);
    chk32("rst_mem_addr",   mem_addr_o,   32'h0);
    chk32("rst_mem_wdata",  mem_wdata_o,  32'h0);
    chk32("rst_inst_o",     inst_o,       32'h0);
    chk32("rst_data_rdata", data_rdata_o, 32'h0);
    chk1 ("rst_inst_valid", inst_valid_o, 1'b0);
    chk1 ("rst_data_valid", data_valid_o, 1'b0);
    chk1 ("rst_err",        err_o,        1'b0);
    chk1 ("rst_stall",      stall_o,      1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Minimum-latency fetch from 0x4
    ack_delay = 0;
    push_mem(1'b0, 32'h0000_0004, 32'h0);
    push_rsp(1'b0, 32'h0000_0013);
    @(posedge clk); #1;
    inst_ce_i = 1'b1; inst_addr_i = 32'h0000_0004;
    #1;
    chk1("lat_stall_N", stall_o, 1'b1);
    @(posedge clk); #1;
    inst_ce_i = 1'b0;
    @(negedge clk);
    chk1("lat_req_N1",    mem_req_o,    1'b1);
    chk1("lat_stall_N1",  stall_o,      1'b1);
    chk1("lat_valid_N1",  inst_valid_o, 1'b0);
    @(negedge clk);
    chk1 ("lat_valid_N2", inst_valid_o, 1'b1);
    chk32("lat_inst_N2",  inst_o,       32'h0000_0013);
    chk1 ("lat_stall_N2", stall_o,      1'b0);
    chk1 ("lat_req_N2",   mem_req_o,    1'b0);
    wait_done("fetch_done");

    // Load 0x200 alone
    ack_delay = 2;
    push_mem(1'b0, 32'h0000_0200, 32'h0);
    push_rsp(1'b1, 32'h1000_0200);
    do_req(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0200, 32'h0);
    wait_done("load_done");

    // Simultaneous fetch 0x10 and load 0x200
    ack_delay = 1;
`ifdef ARB_FAIR_EN
    push_mem(1'b0, 32'h0000_0010, 32'h0);
    push_rsp(1'b0, 32'h1000_0010);
    push_mem(1'b0, 32'h0000_0200, 32'h0);
    push_rsp(1'b1, 32'h1000_0200);
`else
    push_mem(1'b0, 32'h0000_0200, 32'h0);
    push_rsp(1'b1, 32'h1000_0200);
    push_mem(1'b0, 32'h0000_0010, 32'h0);
    push_rsp(1'b0, 32'h1000_0010);
`endif
    do_req(1'b1, 32'h0000_0010, 1'b1, 1'b0, 32'h0000_0200, 32'h0);
    wait_done("contend_done");

    // Store 0x300 <- 0xDEADBEEF, bus held for several wait cycles
    ack_delay = 3;
    push_mem(1'b1, 32'h0000_0300, 32'hDEAD_BEEF);
    push_rsp(1'b1, 32'h1000_0300);
    do_req(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0300, 32'hDEAD_BEEF);
    wait_done("store_done");

    // Ack in the last allowed cycle wins over the timeout
    ack_delay = 14;
    push_mem(1'b0, 32'h0000_0020, 32'h0);
    push_rsp(1'b0, 32'h1000_0020);
    do_req(1'b1, 32'h0000_0020, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_done("ack15_done");
    chk1("ack15_err", err_o, 1'b0);

    // No ack: abort after 15 busy cycles, data forced to 0, err set
    ack_delay = 1000;
    push_mem(1'b0, 32'h0000_0040, 32'h0);
    push_rsp(1'b1, 32'h0000_0000);
    do_req(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
    hi_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (mem_req_o !== 1'b1) break;
      hi_cnt++;
    end
    chk32("timeout_req_cycles", 32'(hi_cnt), 32'd15);
    wait_done("timeout_done");
    chk1("timeout_err", err_o, 1'b1);

    // err stays set across a normal transaction
    ack_delay = 0;
    push_mem(1'b0, 32'h0000_0008, 32'h0);
    push_rsp(1'b0, 32'h1000_0008);
    do_req(1'b1, 32'h0000_0008, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_done("sticky_done");
    chk1("err_sticky", err_o, 1'b1);

    // Reset in BUSY_D, then a late ack: no response, everything cleared
    ack_delay = 1000;
    push_mem(1'b0, 32'h0000_0500, 32'h0);
    do_req(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0500, 32'h0);
    @(negedge clk);
    chk1("busy_before_rst", mem_req_o, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ack_force = 1'b1;
    @(posedge clk); #1;
    ack_force = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1 ("rst_mid_req",    mem_req_o,    1'b0);
      chk1 ("rst_mid_ivalid", inst_valid_o, 1'b0);
      chk1 ("rst_mid_dvalid", data_valid_o, 1'b0);
    end
    chk32("rst_mid_addr",  mem_addr_o,   32'h0);
    chk32("rst_mid_inst",  inst_o,       32'h0);
    chk32("rst_mid_rdata", data_rdata_o, 32'h0);
    chk1 ("rst_mid_err",   err_o,        1'b0);
    chk1 ("rst_mid_stall", stall_o,      1'b0);

    @(negedge clk);
    chk32("mem_queue_empty", 32'(exp_mem.size()), 32'd0);
    chk32("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test expected completion");
    $fatal(1, "bench did not complete");
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width.
REQ-002 SHALL have parameter DATA_W, default 32: data width.
REQ-003 SHALL have parameter MAX_WAIT, default 15: cycles allowed for mem_ack before abort; range 1..255.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port inst_ce_i, input, 1: fetch request.
REQ-007 SHALL have port inst_addr_i, input, ADDR_W: fetch address.
REQ-008 SHALL have port inst_o, output, DATA_W: fetched instruction, registered.
REQ-009 SHALL have port inst_valid_o, output, 1: one-cycle pulse, inst_o valid.
REQ-010 SHALL have port data_ce_i, input, 1: load/store request.
REQ-011 SHALL have port data_we_i, input, 1: 1 = store, 0 = load.
REQ-012 SHALL have port data_addr_i, input, ADDR_W: load/store address.
REQ-013 SHALL have port data_wdata_i, input, DATA_W: store data.
REQ-014 SHALL have port data_rdata_o, output, DATA_W: load data, registered.
REQ-015 SHALL have port data_valid_o, output, 1: one-cycle pulse, load done or store acknowledged.
REQ-016 SHALL have port stall_o, output, 1: CPU hold while any request is pending.
REQ-017 SHALL have ports mem_req_o (output, 1), mem_we_o (output, 1), mem_addr_o (output, ADDR_W), mem_wdata_o (output, DATA_W), mem_rdata_i (input, DATA_W), mem_ack_i (input, 1): single-ported unified memory.
REQ-018 SHALL have port err_o, output, 1: sticky timeout flag, cleared only by rst.

Function
REQ-019 SHALL implement FSM states IDLE, BUSY_I, BUSY_D.
REQ-020 In IDLE with data_ce_i=1, SHALL latch the data request and enter BUSY_D next cycle.
REQ-021 In IDLE with only inst_ce_i=1, SHALL latch the fetch request and enter BUSY_I next cycle.
REQ-022 In IDLE with both requests, SHALL grant data first; the fetch stays pending and is granted on the return to IDLE.
REQ-023 SHALL drive mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o from registers; they are valid for the whole BUSY_x state and stable until ack. mem_we_o=0 in BUSY_I.
REQ-024 On mem_ack_i=1 in BUSY_x, SHALL capture mem_rdata_i into inst_o or data_rdata_o, pulse the matching valid one cycle later, and return to IDLE.
REQ-025 Minimum latency: request in IDLE at cycle N, mem_req_o high from N+1, ack at N+1 gives valid at N+2.
REQ-026 Back-to-back: a new request may be accepted in the IDLE cycle that coincides with the valid pulse.
REQ-027 stall_o SHALL be state!=IDLE OR (state==IDLE AND (inst_ce_i OR data_ce_i)), combinational.
REQ-028 SHALL keep a wait counter, cleared on BUSY_x entry and incremented each BUSY_x cycle without ack.
REQ-029 When the counter reaches MAX_WAIT without ack, SHALL drop mem_req_o, set err_o, pulse the matching valid with data forced to 0, and return to IDLE.
REQ-030 If ack and timeout occur in the same cycle, ack SHALL win and err_o SHALL be unchanged.
REQ-031 SHALL ignore mem_ack_i while in IDLE.
REQ-032 Request inputs SHALL be sampled only in IDLE; changes during BUSY_x have no effect.

Reset
REQ-033 On rst=1, SHALL set: state IDLE, counter 0, mem_req_o 0, mem_we_o 0, mem_addr_o 0, mem_wdata_o 0, inst_o 0, data_rdata_o 0, both valids 0, err_o 0.
REQ-034 Reset mid-transaction SHALL abandon the transaction with no valid pulse; a late ack after reset is ignored.

Configuration
REQ-035 With ARB_FAIR_EN defined, SHALL keep a last-grant bit (reset: inst). On simultaneous requests, SHALL grant the requester not granted last.
REQ-036 Without ARB_FAIR_EN, SHALL use fixed data-over-fetch priority as in REQ-022.

Structure
REQ-037 SHALL place the FSM state encoding, default widths and MAX_WAIT default in shared package riscv_pkg.
REQ-038 SHALL implement the wait counter and timeout compare as sub-module arb_wdog.

Verification
REQ-039 Fetch addr 0x0000_0004, ack at first BUSY cycle with rdata 0x0000_0013 -> inst_o=0x0000_0013, inst_valid_o pulse at N+2, stall_o high for N..N+1.
REQ-040 Simultaneous fetch 0x10 and load 0x200 -> data granted first (mem_addr_o=0x200), then fetch (0x10); with ARB_FAIR_EN and last grant=data -> fetch first.
REQ-041 Store addr 0x300, data 0xDEAD_BEEF -> mem_we_o=1, mem_wdata_o=0xDEAD_BEEF held until ack; data_valid_o pulse after ack.
REQ-042 No ack for MAX_WAIT=15 cycles -> mem_req_o drops, err_o=1 sticky, valid pulse with data 0; ack in cycle 15 -> normal completion, err_o=0.
REQ-043 rst=1 in BUSY_D, then ack -> no valid pulse, all outputs 0, FSM in IDLE.
